// File: rtl/cntr_cmp_pkg.sv
// Shared types and constants for the counter compare/interrupt stage.
package cntr_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        FIRED = 2'b10
    } cntr_cmp_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cntr_compare.sv
// Compare stage: raises a 1-cycle match pulse and a sticky irq when the counter equals a loaded value.
// Optional missed-ack overflow flag enabled by defining CNTR_CMP_OVF_EN.
module cntr_compare
    import cntr_cmp_pkg::*;
#(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] cntr_i,
    input  logic                     cmp_valid_i,
    output logic                     cmp_ready_o,
    input  logic [COUNTER_WIDTH-1:0] cmp_data_i,
    input  logic                     mode_i,
    input  logic                     disarm_i,
    input  logic                     irq_ack_i,
    output logic                     match_o,
    output logic                     irq_o,
    output logic                     armed_o,
    output logic                     ovf_o
);

    cntr_cmp_state_t          state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cmp_q, cmp_d;
    logic                     mode_q, mode_d;
    logic                     lock_q, lock_d;
    logic                     match_q;
    logic                     irq_q, irq_d;
    logic                     handshake;
    logic                     equal;
    logic                     hit;

    assign cmp_ready_o = (state_q != ARMED);
    assign handshake   = cmp_valid_i & cmp_ready_o;
    assign equal       = (cntr_i == cmp_q);
    assign hit         = (state_q == ARMED) & equal & ~lock_q;

    // lock suppresses repeat hits in periodic mode until the counter moves off the compare value
    always_comb begin
        state_d = state_q;
        cmp_d   = cmp_q;
        mode_d  = mode_q;
        lock_d  = lock_q;
        case (state_q)
            ARMED: begin
                if (hit && mode_q == MODE_PERIODIC) begin
                    lock_d = 1'b1;
                end else if (!equal) begin
                    lock_d = 1'b0;
                end
                if (disarm_i) begin
                    state_d = IDLE;
                end else if (hit && mode_q == MODE_ONESHOT) begin
                    state_d = FIRED;
                end
            end
            default: begin
                if (handshake) begin
                    state_d = ARMED;
                    cmp_d   = cmp_data_i;
                    mode_d  = mode_i;
                    lock_d  = 1'b0;
                end
            end
        endcase
        irq_d = irq_q;
        if (hit) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmp_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            lock_q  <= 1'b0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            mode_q  <= mode_d;
            lock_q  <= lock_d;
            match_q <= hit;
            irq_q   <= irq_d;
        end
    end

    assign match_o = match_q;
    assign irq_o   = irq_q;
    assign armed_o = (state_q == ARMED);

`ifdef CNTR_CMP_OVF_EN
    logic ovf_q, ovf_d;

    // A hit landing on an unacknowledged irq means software missed an event
    always_comb begin
        ovf_d = ovf_q;
        if (hit && irq_q && !irq_ack_i) begin
            ovf_d = 1'b1;
        end else if (irq_ack_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_cntr_compare.sv
// Directed bench for cntr_compare; models the upstream counter with a local enable.
module tb_cntr_compare;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cntr;
    logic       en;
    logic       cmp_valid;
    logic       cmp_ready;
    logic [7:0] cmp_data;
    logic       mode;
    logic       disarm;
    logic       irq_ack;
    logic       match;
    logic       irq;
    logic       armed;
    logic       ovf;

    int testsRun    = 0;
    int testsFailed = 0;
    int pulses, firstIdx, lastIdx;

`ifdef CNTR_CMP_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    cntr_compare #(.COUNTER_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cntr_i     (cntr),
        .cmp_valid_i(cmp_valid),
        .cmp_ready_o(cmp_ready),
        .cmp_data_i (cmp_data),
        .mode_i     (mode),
        .disarm_i   (disarm),
        .irq_ack_i  (irq_ack),
        .match_o    (match),
        .irq_o      (irq),
        .armed_o    (armed),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cntr <= 8'h00;
        else if (en) cntr <= cntr + 8'h01;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic m,
                                 input logic dis, input logic ack);
        cmp_valid = v;
        cmp_data  = d;
        mode      = m;
        disarm    = dis;
        irq_ack   = ack;
        step();
        cmp_valid = 1'b0;
        disarm    = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic countPulses(input int n, output int cnt, output int first, output int last);
        cnt   = 0;
        first = -1;
        last  = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (match) begin
                if (cnt == 0) first = i;
                last = i;
                cnt++;
            end
        end
    endtask

    task automatic waitCntr(input logic [7:0] value);
        for (int i = 0; i < 300; i++) begin
            if (cntr == value) break;
            step();
        end
        checkOutput("waitCntr", cntr, value);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cmp_valid = 1'b0;
        cmp_data  = 8'h00;
        mode      = 1'b0;
        disarm    = 1'b0;
        irq_ack   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_match", match, 0);
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_armed", armed, 0);
        checkOutput("rst_ready", cmp_ready, 1);
        checkOutput("rst_ovf", ovf, 0);

        // One-shot at 0x05 with counter starting at 0x00
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        checkOutput("os_armed", armed, 1);
        checkOutput("os_ready", cmp_ready, 0);
        en = 1'b1;
        countPulses(5, pulses, firstIdx, lastIdx);
        checkOutput("os_early", pulses, 0);
        step();
        checkOutput("os_match", match, 1);
        step();
        checkOutput("os_match_end", match, 0);
        checkOutput("os_irq", irq, 1);
        checkOutput("os_ready_after", cmp_ready, 1);
        checkOutput("os_armed_after", armed, 0);
        countPulses(300, pulses, firstIdx, lastIdx);
        checkOutput("os_no_wrap", pulses, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("ack_irq", irq, 0);

        // Periodic at 0xFF across wrap
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        checkOutput("per_armed", armed, 1);
        countPulses(512, pulses, firstIdx, lastIdx);
        checkOutput("per_count", pulses, 2);
        checkOutput("per_gap", lastIdx - firstIdx, 256);
        checkOutput("per_still_armed", armed, 1);
        checkOutput("per_irq", irq, 1);

        // Ack in the same cycle as a hit: set wins
        waitCntr(8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("col_match", match, 1);
        checkOutput("col_irq", irq, 1);
        // Hit with irq pending and no ack
        waitCntr(8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_match", match, 1);
        checkOutput("ovf_irq", irq, 1);
        checkOutput("ovf_set", ovf, OVF_EN);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_ack_irq", irq, 0);
        checkOutput("ovf_ack_ovf", ovf, 0);

        // Stalled counter: one pulse per equality episode
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_disarm", armed, 0);
        waitCntr(8'h10);
        en = 1'b0;
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_armed", armed, 1);
        checkOutput("stall_no_early", match, 0);
        countPulses(10, pulses, firstIdx, lastIdx);
        checkOutput("stall_one", pulses, 1);
        checkOutput("stall_first", firstIdx, 0);
        en = 1'b1;
        countPulses(300, pulses, firstIdx, lastIdx);
        checkOutput("stall_wrap", pulses, 1);
        checkOutput("stall_armed_end", armed, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("stall_ack", irq, 0);

        // Disarm one count before the compare value
        waitCntr(8'h0F);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("dis_early_armed", armed, 0);
        checkOutput("dis_early_match", match, 0);
        countPulses(5, pulses, firstIdx, lastIdx);
        checkOutput("dis_early_none", pulses, 0);
        checkOutput("dis_early_irq", irq, 0);

        // Disarm on the hit cycle: pulse still fires
        applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
        waitCntr(8'h20);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("dis_hit_match", match, 1);
        checkOutput("dis_hit_armed", armed, 0);
        checkOutput("dis_hit_irq", irq, 1);
        step();
        checkOutput("dis_hit_single", match, 0);

        // Asynchronous reset while armed with irq set
        applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_armed", armed, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_match", match, 0);
        checkOutput("arst_irq", irq, 0);
        checkOutput("arst_armed", armed, 0);
        checkOutput("arst_ready", cmp_ready, 1);
        checkOutput("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_match", match, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
